linear_backward: RTL and testbench
==================================

LINEAR_BACKWARD -- requirements
Module: linear_backward

Interface
REQ-001 Parameter INPUT_SIZE, default 4, number of layer inputs (forward fan-in).
REQ-002 Parameter OUTPUT_SIZE, default 4, number of layer outputs (forward fan-out).
REQ-003 Parameter COUNT, default 1, number of samples per batch.
REQ-004 Port clk  input  1  the single clock; all state updates on rising edge.
REQ-005 Port rst  input  1  reset; synchronous and active-high.
REQ-006 Port enable  input  1  start request, sampled in IDLE only.
REQ-007 Port grad_out  input  [COUNT][OUTPUT_SIZE][32]  upstream gradient dL/dY, IEEE-754 single.
REQ-008 Port weights  input  [INPUT_SIZE][OUTPUT_SIZE][32]  layer weights W, IEEE-754 single.
REQ-009 Port grad_in  output  [COUNT][INPUT_SIZE][32]  computed dL/dX, IEEE-754 single, registered.
REQ-010 Port busy  output  1  high in ACCUM.
REQ-011 Port done  output  1  high in DONE.

Function
REQ-012 The block SHALL compute grad_in[r][i] = sum over j of grad_out[r][j] * weights[i][j] (dY times W transposed).
REQ-013 FSM states SHALL be IDLE, ACCUM, DONE; reset state IDLE.
REQ-014 IDLE with enable=1 at an edge: capture grad_out and weights into internal registers, clear r/i/j counters and accumulator to +0.0, enter ACCUM.
REQ-015 ACCUM: exactly one multiply-accumulate per cycle, acc = acc + g[r][j]*w[i][j], single rounding per multiply and per add, round-to-nearest-even.
REQ-016 Iteration order SHALL be j innermost, then i, then r; each (r,i) accumulation starts from +0.0.
REQ-017 After the j=OUTPUT_SIZE-1 MAC, the result SHALL be written to grad_in[r][i] at that same edge; other grad_in elements unchanged.
REQ-018 After the final MAC (r=COUNT-1, i=INPUT_SIZE-1, j=OUTPUT_SIZE-1), the FSM SHALL enter DONE; done rises exactly COUNT*INPUT_SIZE*OUTPUT_SIZE cycles after the enable-sampling edge (16 for defaults).
REQ-019 DONE SHALL hold done=1 and grad_in stable until enable is sampled low, then return to IDLE.
REQ-020 Input changes on grad_out/weights and enable deassertion during ACCUM SHALL be ignored; operation completes on captured operands.
REQ-021 In IDLE grad_in SHALL retain the last results until the next computation overwrites them element by element.
REQ-022 Counters SHALL wrap to zero at their limits; no out-of-range index is ever used.
REQ-023 Denormal operands SHALL be flushed to zero; NaN/Inf propagate per IEEE-754 without trapping.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, busy=0, done=0, all grad_in elements to 0x00000000, counters and accumulator cleared, regardless of state (including mid-ACCUM).
REQ-025 rst SHALL have priority over enable on the same edge.

Structure
REQ-026 A shared package SHALL hold the float32 word typedef, the FSM state enum and the +0.0 constant.
REQ-027 One sub-module fp_mac SHALL implement the combinational single-precision multiply-add; linear_backward instantiates exactly one.

Verification
REQ-028 grad_out {1,2,3,4}, all weights 0.5, enable -> done after 16 cycles, every grad_in = 5.0, busy high for those 16 cycles.
REQ-029 weights = identity, grad_out {1.5,-2,0.25,8} -> grad_in {1.5,-2,0.25,8} exactly.
REQ-030 grad_out {1,2,3,4}, weights row i all -0.5 for odd i, 0.5 for even i -> grad_in {5,-5,5,-5}.
REQ-031 rst pulsed at cycle 7 of ACCUM -> next cycle IDLE, done=0, busy=0, grad_in all 0x00000000; fresh enable then yields correct results in 16 cycles.
REQ-032 Change grad_out to all 9.0 and drop enable during ACCUM -> results still from captured operands; done held until enable is low.
REQ-033 COUNT=2 build, sample 1 grad_out all 1.0, weights all 0.5 -> sample 1 grad_in all 2.0, done after 32 cycles.

Source files
------------

// File: rtl/linear_backward_pkg.sv
// Shared types and constants for the linear-layer backward pass.
// Holds the float32 word type, FSM states and a few IEEE-754 helpers.
package linear_backward_pkg;

  localparam int unsigned FP_W = 32;

  typedef logic [FP_W-1:0] f32_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam f32_t FP_POS_ZERO = 32'h0000_0000;
  localparam f32_t FP_QNAN     = 32'h7FC0_0000;

  function automatic f32_t fp_inf(input logic s);
    return {s, 8'hFF, 23'd0};
  endfunction

  function automatic f32_t fp_zero(input logic s);
    return {s, 31'd0};
  endfunction

endpackage

// File: rtl/linear_backward_fp_mac.sv
// Combinational float32 multiply-add: sum_c = acc + a*b, each op rounded
// to nearest-even, denormal operands and underflowing results flushed to zero.
module fp_mac
  import linear_backward_pkg::*;
(
  input  logic [FP_W-1:0] acc,
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] sum_c
);

  function automatic f32_t fp_mul(input f32_t x, input f32_t y);
    logic               s;
    logic               x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
    logic [47:0]        p;
    logic [23:0]        m;
    logic [24:0]        mr;
    logic               g, st;
    logic signed [9:0]  e;
    f32_t               r;
    s      = x[31] ^ y[31];
    x_zero = (x[30:23] == 8'd0);
    y_zero = (y[30:23] == 8'd0);
    x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    y_inf  = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
    x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    p = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
    e = $signed({2'b00, x[30:23]}) + $signed({2'b00, y[30:23]}) - 10'sd127;
    if (p[47]) begin
      m  = p[47:24];
      g  = p[23];
      st = |p[22:0];
      e  = e + 10'sd1;
    end else begin
      m  = p[46:23];
      g  = p[22];
      st = |p[21:0];
    end
    mr = {1'b0, m} + 25'(g & (st | m[0]));
    if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero)) begin
      r = FP_QNAN;
    end else if (x_inf || y_inf) begin
      r = fp_inf(s);
    end else if (x_zero || y_zero || (e <= 10'sd0)) begin
      r = fp_zero(s);
    end else begin
      e = e + $signed({9'd0, mr[24]});
      if (e >= 10'sd255) r = fp_inf(s);
      else               r = {s, e[7:0], mr[24] ? mr[23:1] : mr[22:0]};
    end
    return r;
  endfunction

  function automatic f32_t fp_add(input f32_t x, input f32_t y);
    logic               x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
    f32_t               big, sml, r;
    logic [7:0]         d;
    logic [53:0]        ext;
    logic [26:0]        mb, ms, m27;
    logic [27:0]        sum28;
    logic [24:0]        mr;
    logic [4:0]         lz;
    logic               found, g, st;
    logic signed [9:0]  e;
    x_zero = (x[30:23] == 8'd0);
    y_zero = (y[30:23] == 8'd0);
    x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    y_inf  = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
    x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    big = (y[30:0] > x[30:0]) ? y : x;
    sml = (y[30:0] > x[30:0]) ? x : y;
    d   = big[30:23] - sml[30:23];
    mb  = {1'b1, big[22:0], 3'b000};
    // Shifted-out bits collapse into a sticky LSB below guard/round.
    ext = 54'({1'b1, sml[22:0], 30'd0}) >> ((d > 8'd31) ? 5'd31 : d[4:0]);
    ms  = {ext[53:28], ext[27] | (|ext[26:0])};
    e   = $signed({2'b00, big[30:23]});
    m27 = 27'd0;
    if (big[31] == sml[31]) begin
      sum28 = {1'b0, mb} + {1'b0, ms};
      if (sum28[27]) begin
        m27 = {sum28[27:2], sum28[1] | sum28[0]};
        e   = e + 10'sd1;
      end else begin
        m27 = sum28[26:0];
      end
    end else begin
      sum28 = 28'd0;
      m27   = mb - ms;
    end
    lz    = 5'd0;
    found = 1'b0;
    for (int k = 26; k >= 0; k--) begin
      if (!found) begin
        if (m27[k]) found = 1'b1;
        else        lz = lz + 5'd1;
      end
    end
    m27 = m27 << lz;
    e   = e - $signed({5'd0, lz});
    g   = m27[2];
    st  = |m27[1:0];
    mr  = {1'b0, m27[26:3]} + 25'(g & (st | m27[3]));
    if (x_nan || y_nan || (x_inf && y_inf && (x[31] != y[31]))) begin
      r = FP_QNAN;
    end else if (x_inf) begin
      r = x;
    end else if (y_inf) begin
      r = y;
    end else if (x_zero && y_zero) begin
      r = fp_zero(x[31] & y[31]);
    end else if (x_zero) begin
      r = y;
    end else if (y_zero) begin
      r = x;
    end else if (!found) begin
      r = FP_POS_ZERO;
    end else if (e <= 10'sd0) begin
      r = fp_zero(big[31]);
    end else begin
      e = e + $signed({9'd0, mr[24]});
      if (e >= 10'sd255) r = fp_inf(big[31]);
      else               r = {big[31], e[7:0], mr[24] ? mr[23:1] : mr[22:0]};
    end
    return r;
  endfunction

  f32_t prod;

  assign prod  = fp_mul(a, b);
  assign sum_c = fp_add(acc, prod);

endmodule

// File: rtl/linear_backward.sv
// Backward pass of a fully connected layer: grad_in = grad_out * W^T,
// computed one float32 multiply-accumulate per cycle on captured operands.
module linear_backward
  import linear_backward_pkg::*;
#(
  parameter int unsigned INPUT_SIZE  = 4,
  parameter int unsigned OUTPUT_SIZE = 4,
  parameter int unsigned COUNT       = 1
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           enable,
  input  logic [COUNT-1:0][OUTPUT_SIZE-1:0][FP_W-1:0]      grad_out,
  input  logic [INPUT_SIZE-1:0][OUTPUT_SIZE-1:0][FP_W-1:0] weights,
  output logic [COUNT-1:0][INPUT_SIZE-1:0][FP_W-1:0]       grad_in,
  output logic                                           busy,
  output logic                                           done
);

  localparam int unsigned R_W = (COUNT > 1)       ? $clog2(COUNT)       : 1;
  localparam int unsigned I_W = (INPUT_SIZE > 1)  ? $clog2(INPUT_SIZE)  : 1;
  localparam int unsigned J_W = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;

  state_t                                           state;
  logic [R_W-1:0]                                   r_idx;
  logic [I_W-1:0]                                   i_idx;
  logic [J_W-1:0]                                   j_idx;
  f32_t                                             acc;
  logic [COUNT-1:0][OUTPUT_SIZE-1:0][FP_W-1:0]      g_q;
  logic [INPUT_SIZE-1:0][OUTPUT_SIZE-1:0][FP_W-1:0] w_q;
  f32_t                                             mac_sum_c;
  logic                                             last_r, last_i, last_j;

  assign last_r = (r_idx == R_W'(COUNT - 1));
  assign last_i = (i_idx == I_W'(INPUT_SIZE - 1));
  assign last_j = (j_idx == J_W'(OUTPUT_SIZE - 1));

  fp_mac u_fp_mac (
    .acc   (acc),
    .a     (g_q[r_idx][j_idx]),
    .b     (w_q[i_idx][j_idx]),
    .sum_c (mac_sum_c)
  );

  // Control, counters, accumulator and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      r_idx   <= '0;
      i_idx   <= '0;
      j_idx   <= '0;
      acc     <= FP_POS_ZERO;
      g_q     <= '0;
      w_q     <= '0;
      grad_in <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (enable) begin
            g_q   <= grad_out;
            w_q   <= weights;
            r_idx <= '0;
            i_idx <= '0;
            j_idx <= '0;
            acc   <= FP_POS_ZERO;
            busy  <= 1'b1;
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (last_j) begin
            // Dot product for (r,i) complete: commit and restart from +0.0.
            grad_in[r_idx][i_idx] <= mac_sum_c;
            acc   <= FP_POS_ZERO;
            j_idx <= '0;
            if (last_i) begin
              i_idx <= '0;
              if (last_r) begin
                r_idx <= '0;
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= ST_DONE;
              end else begin
                r_idx <= r_idx + R_W'(1);
              end
            end else begin
              i_idx <= i_idx + I_W'(1);
            end
          end else begin
            acc   <= mac_sum_c;
            j_idx <= j_idx + J_W'(1);
          end
        end
        ST_DONE: begin
          if (!enable) begin
            done  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_linear_backward.sv
// Randomized self-checking bench for linear_backward against a real-arithmetic
// reference model (float32 rounding emulated via double precision).
`timescale 1ns/1ps
module tb_linear_backward;

  localparam int unsigned IN  = 4;
  localparam int unsigned OUT = 4;
  localparam logic [31:0] F_ONE   = 32'h3F80_0000;
  localparam logic [31:0] F_TWO   = 32'h4000_0000;
  localparam logic [31:0] F_HALF  = 32'h3F00_0000;
  localparam logic [31:0] F_NHALF = 32'hBF00_0000;
  localparam logic [31:0] F_NINE  = 32'h4110_0000;
  localparam logic [31:0] F_FIVE  = 32'h40A0_0000;
  localparam logic [31:0] F_NFIVE = 32'hC0A0_0000;

  logic clk = 1'b0;
  logic rst, en1, en2;
  logic [0:0][OUT-1:0][31:0]    go1;
  logic [IN-1:0][OUT-1:0][31:0] w1;
  logic [0:0][IN-1:0][31:0]     gi1;
  logic                         busy1, done1;
  logic [1:0][OUT-1:0][31:0]    go2;
  logic [IN-1:0][OUT-1:0][31:0] w2;
  logic [1:0][IN-1:0][31:0]     gi2;
  logic                         busy2, done2;
  logic [1:0][IN-1:0][31:0]     exp_y;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  linear_backward #(.INPUT_SIZE(IN), .OUTPUT_SIZE(OUT), .COUNT(1)) dut (
    .clk(clk), .rst(rst), .enable(en1), .grad_out(go1), .weights(w1),
    .grad_in(gi1), .busy(busy1), .done(done1)
  );

  linear_backward #(.INPUT_SIZE(IN), .OUTPUT_SIZE(OUT), .COUNT(2)) dut2 (
    .clk(clk), .rst(rst), .enable(en2), .grad_out(go2), .weights(w2),
    .grad_in(gi2), .busy(busy2), .done(done2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // float32 -> real, denormals read as signed zero
  function automatic real f2r(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'd0)       d = {x[31], 63'd0};
    else if (x[30:23] == 8'hFF) d = {x[31], 11'h7FF, x[22:0], 29'd0};
    else                        d = {x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // real -> float32, nearest-even, tiny results flushed to signed zero
  function automatic logic [31:0] r2f(input real v);
    logic [63:0] d;
    logic [23:0] m;
    logic        inc;
    int          e;
    d = $realtobits(v);
    if (d[62:52] == 11'h7FF) return (d[51:0] != 52'd0) ? 32'h7FC0_0000 : {d[63], 8'hFF, 23'd0};
    e = int'(d[62:52]) - 896;
    if (e <= 0) return {d[63], 31'd0};
    inc = d[28] & ((|d[27:0]) | d[29]);
    m   = {1'b0, d[51:29]} + 24'(inc);
    if (m[23]) e++;
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    return {d[63], 8'(e), m[22:0]};
  endfunction

  function automatic logic [31:0] mac_ref(input logic [31:0] a, input logic [31:0] g, input logic [31:0] w);
    return r2f(f2r(a) + f2r(r2f(f2r(g) * f2r(w))));
  endfunction

  task automatic compute_ref(input int cnt, input logic [1:0][OUT-1:0][31:0] g,
                             input logic [IN-1:0][OUT-1:0][31:0] w);
    logic [31:0] a;
    for (int r = 0; r < cnt; r++)
      for (int i = 0; i < IN; i++) begin
        a = 32'h0;
        for (int j = 0; j < OUT; j++) a = mac_ref(a, g[r][j], w[i][j]);
        exp_y[r][i] = a;
      end
  endtask

  function automatic logic [31:0] rnd_f();
    return {1'($urandom), 8'($urandom_range(134, 118)), 23'($urandom)};
  endfunction

  // One COUNT=1 operation; perturb scrambles inputs/enable mid-ACCUM, rst_at>0 aborts with reset.
  task automatic run1(input bit perturb, input int rst_at);
    int cycles, busy_n;
    bit seen;
    compute_ref(1, {128'd0, go1}, w1);
    en1 = 1'b1;
    cycles = 0; busy_n = 0; seen = 1'b0;
    while (!seen && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (busy1) busy_n++;
      if (done1) seen = 1'b1;
      if (perturb && cycles == 3) begin
        for (int j = 0; j < OUT; j++) go1[0][j] = F_NINE;
        for (int i = 0; i < IN; i++) w1[i][0] = rnd_f();
        en1 = 1'b0;
      end
      if (perturb && cycles == 6) en1 = 1'b1;
      if (rst_at != 0 && cycles == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        for (int i = 0; i < IN; i++) check($sformatf("rst_y%0d", i), gi1[0][i], 32'h0);
        rst = 1'b0;
        en1 = 1'b0;
        @(negedge clk);
        return;
      end
    end
    check("latency", 32'(cycles - 1), 32'd16);
    check("busy_cycles", 32'(busy_n), 32'd16);
    for (int i = 0; i < IN; i++) check($sformatf("y0_%0d", i), gi1[0][i], exp_y[0][i]);
    repeat (2) begin
      @(negedge clk);
      check("done_hold", 32'(done1), 32'd1);
      check("y_hold", gi1[0][IN-1], exp_y[0][IN-1]);
    end
    en1 = 1'b0;
    @(negedge clk);
    check("done_low", 32'(done1), 32'd0);
    @(negedge clk);
    check("idle_keep", gi1[0][0], exp_y[0][0]);
  endtask

  initial begin
    int  cycles;
    bit  seen;
    rst = 1'b1; en1 = 1'b0; en2 = 1'b0;
    go1 = '0; w1 = '0; go2 = '0; w2 = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy1), 32'd0);
    check("reset_done", 32'(done1), 32'd0);
    check("reset_y", gi1[0][2], 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // {1,2,3,4} with all weights 0.5
    go1[0][0] = F_ONE; go1[0][1] = F_TWO; go1[0][2] = 32'h4040_0000; go1[0][3] = 32'h4080_0000;
    for (int i = 0; i < IN; i++) for (int j = 0; j < OUT; j++) w1[i][j] = F_HALF;
    run1(1'b0, 0);
    for (int i = 0; i < IN; i++) check($sformatf("half_%0d", i), gi1[0][i], F_FIVE);

    // identity weights pass the gradient straight through
    go1[0][0] = 32'h3FC0_0000; go1[0][1] = 32'hC000_0000; go1[0][2] = 32'h3E80_0000; go1[0][3] = 32'h4100_0000;
    for (int i = 0; i < IN; i++) for (int j = 0; j < OUT; j++) w1[i][j] = (i == j) ? F_ONE : 32'h0;
    run1(1'b0, 0);
    check("ident_0", gi1[0][0], 32'h3FC0_0000);
    check("ident_1", gi1[0][1], 32'hC000_0000);
    check("ident_2", gi1[0][2], 32'h3E80_0000);
    check("ident_3", gi1[0][3], 32'h4100_0000);

    // alternating-sign rows
    go1[0][0] = F_ONE; go1[0][1] = F_TWO; go1[0][2] = 32'h4040_0000; go1[0][3] = 32'h4080_0000;
    for (int i = 0; i < IN; i++) for (int j = 0; j < OUT; j++) w1[i][j] = (i % 2 == 1) ? F_NHALF : F_HALF;
    run1(1'b0, 0);
    for (int i = 0; i < IN; i++) check($sformatf("alt_%0d", i), gi1[0][i], (i % 2 == 1) ? F_NFIVE : F_FIVE);

    // reset mid-ACCUM (enable still high), then a clean rerun
    for (int j = 0; j < OUT; j++) go1[0][j] = rnd_f();
    for (int i = 0; i < IN; i++) for (int j = 0; j < OUT; j++) w1[i][j] = rnd_f();
    run1(1'b0, 7);
    run1(1'b0, 0);

    // operands and enable disturbed during ACCUM
    for (int j = 0; j < OUT; j++) go1[0][j] = rnd_f();
    for (int i = 0; i < IN; i++) for (int j = 0; j < OUT; j++) w1[i][j] = rnd_f();
    run1(1'b1, 0);

    repeat (6) begin
      for (int j = 0; j < OUT; j++) go1[0][j] = rnd_f();
      for (int i = 0; i < IN; i++) for (int j = 0; j < OUT; j++) w1[i][j] = rnd_f();
      run1(1'b0, 0);
    end

    // Inf, NaN-producing inf*0 and a denormal operand
    go1[0][0] = 32'h7F80_0000; go1[0][1] = 32'h0040_0000; go1[0][2] = F_ONE; go1[0][3] = F_TWO;
    for (int i = 0; i < IN; i++) for (int j = 0; j < OUT; j++) w1[i][j] = rnd_f();
    w1[1][0] = 32'h0;
    run1(1'b0, 0);

    // two-sample batch
    for (int j = 0; j < OUT; j++) begin
      go2[0][j] = rnd_f();
      go2[1][j] = F_ONE;
    end
    for (int i = 0; i < IN; i++) for (int j = 0; j < OUT; j++) w2[i][j] = F_HALF;
    compute_ref(2, go2, w2);
    en2 = 1'b1;
    cycles = 0; seen = 1'b0;
    while (!seen && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (done2) seen = 1'b1;
    end
    check("c2_latency", 32'(cycles - 1), 32'd32);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < IN; i++) check($sformatf("c2_y%0d_%0d", r, i), gi2[r][i], exp_y[r][i]);
    for (int i = 0; i < IN; i++) check($sformatf("c2_two_%0d", i), gi2[1][i], F_TWO);
    en2 = 1'b0;
    @(negedge clk);
    check("c2_done_low", 32'(done2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
